// File: rtl/nonce_scheduler_if.sv
// ---------------------------------------------------------------------------
// nonce_scheduler_if
//
// Purpose: bundles the control, per-core handshake and status signals of the
// nonce scheduler so the miner top level and the scheduler share one port.
//
// Signals:
//   start          : one-cycle pulse, begin a search at start_nonce
//   abort          : one-cycle pulse, cancel the current search
//   start_nonce    : first nonce of the search, sampled with start
//   core_done      : per-core one-cycle pulse, hash finished
//   core_valid     : per-core, result met target (qualified by core_done)
//   core_start     : one-hot pulse, launch a hash on the selected core
//   dispatch_nonce : nonce for the core selected by core_start
//   busy           : search in progress (dispatching or draining)
//   found          : level, a winning nonce is held in found_nonce
//   found_nonce    : winning nonce
//   exhausted      : level, nonce space ran out without a hit
//   hash_count     : completed-hash counter (zero unless stats are built in)
//
// Modports: master = miner top level / cores side, slave = scheduler.
// ---------------------------------------------------------------------------
interface nonce_scheduler_if #(
    parameter int NUM_CORES = 4,
    parameter int NONCE_W   = 32
);
    logic                 start;
    logic                 abort;
    logic [NONCE_W-1:0]   start_nonce;
    logic [NUM_CORES-1:0] core_done;
    logic [NUM_CORES-1:0] core_valid;
    logic [NUM_CORES-1:0] core_start;
    logic [NONCE_W-1:0]   dispatch_nonce;
    logic                 busy;
    logic                 found;
    logic [NONCE_W-1:0]   found_nonce;
    logic                 exhausted;
    logic [31:0]          hash_count;

    modport master (
        output start, abort, start_nonce, core_done, core_valid,
        input  core_start, dispatch_nonce, busy, found, found_nonce,
               exhausted, hash_count
    );

    modport slave (
        input  start, abort, start_nonce, core_done, core_valid,
        output core_start, dispatch_nonce, busy, found, found_nonce,
               exhausted, hash_count
    );
endinterface

// File: rtl/nonce_scheduler.sv
// ---------------------------------------------------------------------------
// nonce_scheduler
//
// Purpose: hands consecutive nonces round-robin to NUM_CORES hashing cores
// (at most one launch per cycle), remembers the nonce each core is working
// on, and reports the first valid nonce found or exhaustion of the nonce
// space. An abort drains outstanding work and returns to idle silently.
//
// Ports:
//   clk   : system clock, rising edge
//   n_rst : asynchronous active-low reset (cores share this reset)
//   bus   : nonce_scheduler_if.slave, see the interface file for signals
//
// Parameters:
//   NUM_CORES : number of hashing cores, 2..8
//   NONCE_W   : nonce width in bits
//
// Build option:
//   NONCE_SCHED_STATS_EN : when defined, hash_count counts accepted core
//   completions (saturating, cleared by start). When undefined hash_count
//   is tied to zero and no counter is built.
// ---------------------------------------------------------------------------
module nonce_scheduler #(
    parameter int NUM_CORES = 4,
    parameter int NONCE_W   = 32
) (
    input  logic              clk,
    input  logic              n_rst,
    nonce_scheduler_if.slave  bus
);
    localparam int RR_W = $clog2(NUM_CORES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DISPATCH,
        S_DRAIN,
        S_FOUND,
        S_EXHAUSTED
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_CORES-1:0] core_busy_q, core_busy_d;
    logic [NONCE_W-1:0]   inflight_q [NUM_CORES];
    logic [NONCE_W-1:0]   next_nonce_q, next_nonce_d;
    logic [RR_W-1:0]      rr_q, rr_d;
    logic                 hit_q, hit_d;
    logic                 last_q, last_d;
    logic                 discard_q, discard_d;
    logic [NONCE_W-1:0]   found_nonce_q, found_nonce_d;
    logic                 busy_q, found_q, exhausted_q;

    logic                 dispatch_en;
    logic                 grant_valid;
    logic [RR_W-1:0]      grant_idx;
    logic [RR_W:0]        cand;
    logic [NUM_CORES-1:0] grant_oh;
    logic                 grant_any;
    logic [NUM_CORES-1:0] done_acc;
    logic [NUM_CORES-1:0] valid_acc;
    logic [RR_W-1:0]      hit_idx;
    logic                 hit_take;
    logic                 start_accept;
    logic                 idle_like;

    // Completions only count for cores we actually launched; stray pulses
    // from idle cores are dropped here.
    assign done_acc  = bus.core_done & core_busy_q;
    assign valid_acc = done_acc & bus.core_valid;

    // last_q guards against ever launching past the final nonce, even for
    // the single cycle in which the FSM is leaving DISPATCH.
    assign dispatch_en = (state_q == S_DISPATCH) && !last_q;

    assign idle_like    = (state_q == S_IDLE) || (state_q == S_FOUND) ||
                          (state_q == S_EXHAUSTED);
    assign start_accept = idle_like && bus.start && !bus.abort;

    // First idle core at or after rr, wrapping. Scanning offsets from the
    // highest down lets the smallest offset overwrite the result last.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            cand = {1'b0, rr_q} + (RR_W + 1)'(k);
            if (cand >= (RR_W + 1)'(NUM_CORES))
                cand = cand - (RR_W + 1)'(NUM_CORES);
            if (!core_busy_q[cand[RR_W-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = cand[RR_W-1:0];
            end
        end
    end

    for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_grant
        assign grant_oh[gi] = dispatch_en && grant_valid &&
                              (grant_idx == RR_W'(gi));
    end

    assign grant_any = |grant_oh;

    // Lowest-index valid result wins when several land together.
    always_comb begin
        hit_idx = '0;
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            if (valid_acc[k])
                hit_idx = RR_W'(k);
        end
    end

    // Once a hit is held, or the search is being discarded, further valid
    // results are ignored. An abort in the same cycle also suppresses it.
    assign hit_take = (|valid_acc) && !hit_q && !discard_q && !bus.abort;

    // A core is never granted and completed in the same cycle: grants only
    // go to idle cores, completions only count for busy ones.
    assign core_busy_d = (core_busy_q | grant_oh) & ~done_acc;

    always_comb begin
        state_d       = state_q;
        next_nonce_d  = next_nonce_q;
        rr_d          = rr_q;
        hit_d         = hit_q;
        last_d        = last_q;
        discard_d     = discard_q;
        found_nonce_d = found_nonce_q;

        case (state_q)
            S_IDLE, S_FOUND, S_EXHAUSTED: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else if (start_accept) begin
                    state_d      = S_DISPATCH;
                    next_nonce_d = bus.start_nonce;
                    hit_d        = 1'b0;
                    last_d       = 1'b0;
                    discard_d    = 1'b0;
                    rr_d         = '0;
                end
            end

            S_DISPATCH: begin
                if (grant_any) begin
                    next_nonce_d = next_nonce_q + NONCE_W'(1);
                    rr_d = (grant_idx == RR_W'(NUM_CORES - 1)) ?
                           '0 : grant_idx + RR_W'(1);
                    if (&next_nonce_q)
                        last_d = 1'b1;
                end
                if (bus.abort)
                    discard_d = 1'b1;
                if (hit_take) begin
                    hit_d         = 1'b1;
                    found_nonce_d = inflight_q[hit_idx];
                end
                if (bus.abort || hit_take || (grant_any && (&next_nonce_q)))
                    state_d = S_DRAIN;
            end

            S_DRAIN: begin
                if (bus.abort)
                    discard_d = 1'b1;
                if (hit_take) begin
                    hit_d         = 1'b1;
                    found_nonce_d = inflight_q[hit_idx];
                end
                // Exit is judged on the registered busy bits, so the final
                // completion is followed by one more DRAIN cycle.
                if (core_busy_q == '0) begin
                    if (discard_q || bus.abort)
                        state_d = S_IDLE;
                    else if (hit_q)
                        state_d = S_FOUND;
                    else
                        state_d = S_EXHAUSTED;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= S_IDLE;
            core_busy_q   <= '0;
            next_nonce_q  <= '0;
            rr_q          <= '0;
            hit_q         <= 1'b0;
            last_q        <= 1'b0;
            discard_q     <= 1'b0;
            found_nonce_q <= '0;
            busy_q        <= 1'b0;
            found_q       <= 1'b0;
            exhausted_q   <= 1'b0;
            for (int k = 0; k < NUM_CORES; k++)
                inflight_q[k] <= '0;
        end else begin
            state_q       <= state_d;
            core_busy_q   <= core_busy_d;
            next_nonce_q  <= next_nonce_d;
            rr_q          <= rr_d;
            hit_q         <= hit_d;
            last_q        <= last_d;
            discard_q     <= discard_d;
            found_nonce_q <= found_nonce_d;
            busy_q        <= (state_d == S_DISPATCH) || (state_d == S_DRAIN);
            found_q       <= (state_d == S_FOUND);
            exhausted_q   <= (state_d == S_EXHAUSTED);
            for (int k = 0; k < NUM_CORES; k++) begin
                if (grant_oh[k])
                    inflight_q[k] <= next_nonce_q;
            end
        end
    end

`ifdef NONCE_SCHED_STATS_EN
    logic [31:0] hash_count_q, hash_count_d;
    logic [RR_W:0] done_cnt;
    logic [32:0]   count_sum;

    always_comb begin
        done_cnt = '0;
        for (int k = 0; k < NUM_CORES; k++)
            done_cnt = done_cnt + {{RR_W{1'b0}}, done_acc[k]};
        count_sum = {1'b0, hash_count_q} + 33'(done_cnt);
        if (start_accept)
            hash_count_d = '0;
        else if (count_sum[32])
            hash_count_d = '1;
        else
            hash_count_d = count_sum[31:0];
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            hash_count_q <= '0;
        else
            hash_count_q <= hash_count_d;
    end

    assign bus.hash_count = hash_count_q;
`else
    assign bus.hash_count = 32'd0;
`endif

    // Launch outputs depend only on registered state and busy bits.
    assign bus.core_start     = grant_oh;
    assign bus.dispatch_nonce = grant_any ? next_nonce_q : '0;
    assign bus.busy           = busy_q;
    assign bus.found          = found_q;
    assign bus.found_nonce    = found_nonce_q;
    assign bus.exhausted      = exhausted_q;
endmodule

// File: tb/tb_nonce_scheduler.sv
// ---------------------------------------------------------------------------
// tb_nonce_scheduler
//
// Purpose: directed self-checking bench for nonce_scheduler with 4 cores and
// 32-bit nonces. Inputs change and outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_nonce_scheduler;
    localparam int NC = 4;
    localparam int NW = 32;

    logic clk;
    logic n_rst;
    int   checks = 0;
    int   errors = 0;

    nonce_scheduler_if #(.NUM_CORES(NC), .NONCE_W(NW)) bus ();

    nonce_scheduler #(.NUM_CORES(NC), .NONCE_W(NW)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run still active at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    always @(negedge clk) begin
        if (bus.core_start != '0)
            $display("[%0t] dispatch core_start=%b nonce=0x%08h", $time, bus.core_start, bus.dispatch_nonce);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse_start(input logic [NW-1:0] nonce);
        bus.start       = 1'b1;
        bus.start_nonce = nonce;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        n_rst          = 1'b0;
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.start_nonce = '0;
        bus.core_done  = '0;
        bus.core_valid = '0;
        tick();
        checks++; if (bus.core_start !== 4'b0000) begin errors++; $display("FAIL reset_core_start: got %b expected 0000", bus.core_start); end
        checks++; if (bus.dispatch_nonce !== 32'h0) begin errors++; $display("FAIL reset_dispatch_nonce: got %h expected 0", bus.dispatch_nonce); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.found !== 1'b0 || bus.exhausted !== 1'b0) begin errors++; $display("FAIL reset_flags: got found=%b exhausted=%b expected 0 0", bus.found, bus.exhausted); end
        checks++; if (bus.found_nonce !== 32'h0) begin errors++; $display("FAIL reset_found_nonce: got %h expected 0", bus.found_nonce); end
        checks++; if (bus.hash_count !== 32'h0) begin errors++; $display("FAIL reset_hash_count: got %0d expected 0", bus.hash_count); end
        tick();
        n_rst = 1'b1;
        tick();
        checks++; if (bus.busy !== 1'b0 || bus.core_start !== 4'b0000) begin errors++; $display("FAIL post_reset_idle: got busy=%b core_start=%b expected 0 0000", bus.busy, bus.core_start); end
        $display("test_reset done");
    endtask

    task automatic test_start_abort_same_cycle();
        bus.start       = 1'b1;
        bus.abort       = 1'b1;
        bus.start_nonce = 32'h50;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL start_abort_busy: got %b expected 0", bus.busy); end
        tick();
        checks++; if (bus.core_start !== 4'b0000) begin errors++; $display("FAIL start_abort_core_start: got %b expected 0000", bus.core_start); end
        $display("test_start_abort_same_cycle done");
    endtask

    task automatic test_round_robin();
        logic [NC-1:0] exp_cs;
        pulse_start(32'h10);
        for (int i = 0; i < NC; i++) begin
            if (i != 0) tick();
            exp_cs = 4'b0001 << i;
            checks++; if (bus.core_start !== exp_cs || bus.dispatch_nonce !== 32'h10 + 32'(i)) begin errors++; $display("FAIL rr_dispatch%0d: got start=%b nonce=%h expected %b %h", i, bus.core_start, bus.dispatch_nonce, exp_cs, 32'h10 + 32'(i)); end
            checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rr_busy%0d: got %b expected 1", i, bus.busy); end
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (bus.core_start !== 4'b0000) begin errors++; $display("FAIL rr_no_more%0d: got %b expected 0000", i, bus.core_start); end
        end
        $display("test_round_robin done");
    endtask

    task automatic test_single_hit();
        bus.core_done  = 4'b0100;
        bus.core_valid = 4'b0100;
        tick();
        bus.core_done  = '0;
        bus.core_valid = '0;
        checks++; if (bus.busy !== 1'b1 || bus.found !== 1'b0) begin errors++; $display("FAIL hit_drain: got busy=%b found=%b expected 1 0", bus.busy, bus.found); end
        checks++; if (bus.core_start !== 4'b0000) begin errors++; $display("FAIL hit_no_regrant: got %b expected 0000", bus.core_start); end
        bus.core_done = 4'b1011;
        tick();
        bus.core_done = '0;
        checks++; if (bus.found !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL hit_last_drain: got found=%b busy=%b expected 0 1", bus.found, bus.busy); end
        tick();
        checks++; if (bus.found !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL hit_found: got found=%b busy=%b expected 1 0", bus.found, bus.busy); end
        checks++; if (bus.found_nonce !== 32'h12) begin errors++; $display("FAIL hit_found_nonce: got %h expected 00000012", bus.found_nonce); end
        $display("test_single_hit done");
    endtask

    task automatic test_simultaneous_hits();
        logic [NC-1:0] exp_cs;
        pulse_start(32'h100);
        for (int i = 0; i < NC; i++) begin
            if (i != 0) tick();
            exp_cs = 4'b0001 << i;
            checks++; if (bus.core_start !== exp_cs || bus.dispatch_nonce !== 32'h100 + 32'(i)) begin errors++; $display("FAIL sim_dispatch%0d: got start=%b nonce=%h expected %b %h", i, bus.core_start, bus.dispatch_nonce, exp_cs, 32'h100 + 32'(i)); end
        end
        tick();
        bus.core_done  = 4'b1010;
        bus.core_valid = 4'b1010;
        tick();
        bus.core_done  = 4'b0101;
        bus.core_valid = 4'b0000;
        tick();
        bus.core_done = '0;
        checks++; if (bus.found !== 1'b0) begin errors++; $display("FAIL sim_not_yet: got found=%b expected 0", bus.found); end
        tick();
        checks++; if (bus.found !== 1'b1 || bus.found_nonce !== 32'h101) begin errors++; $display("FAIL sim_found_nonce: got found=%b nonce=%h expected 1 00000101", bus.found, bus.found_nonce); end
        $display("test_simultaneous_hits done");
    endtask

    task automatic test_exhaustion();
        pulse_start(32'hFFFF_FFFE);
        checks++; if (bus.core_start !== 4'b0001 || bus.dispatch_nonce !== 32'hFFFF_FFFE) begin errors++; $display("FAIL exh_dispatch0: got start=%b nonce=%h expected 0001 fffffffe", bus.core_start, bus.dispatch_nonce); end
        checks++; if (bus.found !== 1'b0) begin errors++; $display("FAIL exh_found_cleared: got %b expected 0", bus.found); end
        tick();
        checks++; if (bus.core_start !== 4'b0010 || bus.dispatch_nonce !== 32'hFFFF_FFFF) begin errors++; $display("FAIL exh_dispatch1: got start=%b nonce=%h expected 0010 ffffffff", bus.core_start, bus.dispatch_nonce); end
        tick();
        checks++; if (bus.core_start !== 4'b0000 || bus.busy !== 1'b1) begin errors++; $display("FAIL exh_no_wrap: got start=%b nonce=%h busy=%b expected 0000 busy 1", bus.core_start, bus.dispatch_nonce, bus.busy); end
        bus.core_done = 4'b0011;
        tick();
        bus.core_done = '0;
        checks++; if (bus.core_start !== 4'b0000 || bus.exhausted !== 1'b0) begin errors++; $display("FAIL exh_drain: got start=%b exhausted=%b expected 0000 0", bus.core_start, bus.exhausted); end
        tick();
        checks++; if (bus.exhausted !== 1'b1 || bus.busy !== 1'b0 || bus.found !== 1'b0) begin errors++; $display("FAIL exh_final: got exhausted=%b busy=%b found=%b expected 1 0 0", bus.exhausted, bus.busy, bus.found); end
        $display("test_exhaustion done");
    endtask

    task automatic test_abort();
        pulse_start(32'h200);
        checks++; if (bus.core_start !== 4'b0001 || bus.exhausted !== 1'b0) begin errors++; $display("FAIL abort_dispatch0: got start=%b exhausted=%b expected 0001 0", bus.core_start, bus.exhausted); end
        tick();
        tick();
        checks++; if (bus.core_start !== 4'b0100 || bus.dispatch_nonce !== 32'h202) begin errors++; $display("FAIL abort_dispatch2: got start=%b nonce=%h expected 0100 00000202", bus.core_start, bus.dispatch_nonce); end
        bus.abort = 1'b1;
        tick();
        bus.abort      = 1'b0;
        checks++; if (bus.core_start !== 4'b0000 || bus.busy !== 1'b1) begin errors++; $display("FAIL abort_stop: got start=%b busy=%b expected 0000 1", bus.core_start, bus.busy); end
        bus.core_done  = 4'b0001;
        bus.core_valid = 4'b0001;
        tick();
        bus.core_done  = 4'b0010;
        bus.core_valid = 4'b0000;
        checks++; if (bus.found !== 1'b0 || bus.busy !== 1'b1 || bus.core_start !== 4'b0000) begin errors++; $display("FAIL abort_valid_ignored: got found=%b busy=%b start=%b expected 0 1 0000", bus.found, bus.busy, bus.core_start); end
        tick();
        bus.core_done = 4'b0100;
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL abort_draining: got busy=%b expected 1", bus.busy); end
        tick();
        bus.core_done = '0;
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL abort_last_drain: got busy=%b expected 1", bus.busy); end
        tick();
        checks++; if (bus.busy !== 1'b0 || bus.found !== 1'b0 || bus.exhausted !== 1'b0) begin errors++; $display("FAIL abort_idle: got busy=%b found=%b exhausted=%b expected 0 0 0", bus.busy, bus.found, bus.exhausted); end
        $display("test_abort done");
    endtask

    task automatic test_back_to_back_stats();
        logic [31:0] exp_count;
`ifdef NONCE_SCHED_STATS_EN
        exp_count = 32'd10;
`else
        exp_count = 32'd0;
`endif
        pulse_start(32'h300);
        tick();
        tick();
        tick();
        checks++; if (bus.core_start !== 4'b1000 || bus.dispatch_nonce !== 32'h303) begin errors++; $display("FAIL b2b_dispatch3: got start=%b nonce=%h expected 1000 00000303", bus.core_start, bus.dispatch_nonce); end
        tick();
        checks++; if (bus.core_start !== 4'b0000) begin errors++; $display("FAIL b2b_all_busy: got %b expected 0000", bus.core_start); end
        bus.core_done = 4'b0011;
        tick();
        bus.core_done = '0;
        checks++; if (bus.core_start !== 4'b0001 || bus.dispatch_nonce !== 32'h304) begin errors++; $display("FAIL b2b_regrant0: got start=%b nonce=%h expected 0001 00000304", bus.core_start, bus.dispatch_nonce); end
        tick();
        checks++; if (bus.core_start !== 4'b0010 || bus.dispatch_nonce !== 32'h305) begin errors++; $display("FAIL b2b_regrant1: got start=%b nonce=%h expected 0010 00000305", bus.core_start, bus.dispatch_nonce); end
        tick();
        bus.core_done = 4'b1111;
        tick();
        bus.core_done = '0;
        checks++; if (bus.core_start !== 4'b0100 || bus.dispatch_nonce !== 32'h306) begin errors++; $display("FAIL b2b_rr_resume: got start=%b nonce=%h expected 0100 00000306", bus.core_start, bus.dispatch_nonce); end
        tick();
        tick();
        tick();
        checks++; if (bus.core_start !== 4'b0010 || bus.dispatch_nonce !== 32'h309) begin errors++; $display("FAIL b2b_rr_wrap: got start=%b nonce=%h expected 0010 00000309", bus.core_start, bus.dispatch_nonce); end
        tick();
        bus.core_done = 4'b1111;
        bus.abort     = 1'b1;
        tick();
        bus.core_done = '0;
        bus.abort     = 1'b0;
        checks++; if (bus.core_start !== 4'b0000 || bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_drain: got start=%b busy=%b expected 0000 1", bus.core_start, bus.busy); end
        tick();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: got busy=%b expected 0", bus.busy); end
        checks++; if (bus.hash_count !== exp_count) begin errors++; $display("FAIL stats_count: got %0d expected %0d", bus.hash_count, exp_count); end
        bus.core_done = 4'b1111;
        tick();
        bus.core_done = '0;
        checks++; if (bus.hash_count !== exp_count) begin errors++; $display("FAIL stats_idle_done_ignored: got %0d expected %0d", bus.hash_count, exp_count); end
        $display("test_back_to_back_stats done");
    endtask

    initial begin
        test_reset();
        test_start_abort_same_cycle();
        test_round_robin();
        test_single_hit();
        test_simultaneous_hits();
        test_exhaustion();
        test_abort();
        test_back_to_back_stats();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/nonce_scheduler.md
# nonce_scheduler

Distributes candidate nonces across `NUM_CORES` parallel SHA hashing cores and collects their results for the miner top level. The block is started with a base nonce. It hands out consecutive nonces round-robin to idle cores, one per cycle, and tracks the in-flight nonce of each core. It reports the first valid nonce found, or exhaustion of the nonce space. It replaces the single-core begin/increment loop when the miner is built with more than one hashing core.

## Interface
- `NUM_CORES`, 4: number of hashing cores (2..8).
- `NONCE_W`, 32: nonce width in bits.

- `clk` in 1: system clock, rising edge.
- `n_rst` in 1: asynchronous active-low reset.
- `start` in 1: one-cycle pulse; begin a search at `start_nonce`. Ignored while `busy`.
- `abort` in 1: one-cycle pulse; cancel the current search.
- `start_nonce` in `NONCE_W`: first nonce, sampled on `start`.
- `core_done` in `NUM_CORES`: per-core one-cycle pulse, hash finished.
- `core_valid` in `NUM_CORES`: per-core; meaningful only with `core_done`, result met target.
- `core_start` out `NUM_CORES`: one-hot pulse; launch a hash on that core.
- `dispatch_nonce` out `NONCE_W`: nonce for the core selected by `core_start`.
- `busy` out 1: high in DISPATCH and DRAIN.
- `found` out 1: level, high in FOUND.
- `found_nonce` out `NONCE_W`: winning nonce; valid while `found`.
- `exhausted` out 1: level, high in EXHAUSTED.
- `hash_count` out 32: completed-hash counter (see Configuration).

## Operation
- States: IDLE, DISPATCH, DRAIN, FOUND, EXHAUSTED.
- Internal state: `core_busy[NUM_CORES]`, `inflight[NUM_CORES][NONCE_W]`, `next_nonce`, round-robin pointer `rr`, flags `hit`, `last`, `discard`.
- IDLE/FOUND/EXHAUSTED + `start` → DISPATCH. On the same edge: `next_nonce`=`start_nonce`; `hit`, `last`, `discard` cleared; `rr`=0.
- DISPATCH: each cycle with at least one idle core, the scheduler grants the first idle core at or after `rr`, wrapping.
  - `core_start[g]`=1 and `dispatch_nonce`=`next_nonce`.
  - On the edge: `core_busy[g]` set, `inflight[g]`=`next_nonce`, `next_nonce`+1 (mod 2^`NONCE_W`), `rr`=g+1 mod `NUM_CORES`.
- `core_done[i]` clears `core_busy[i]` on that edge. The core can be granted again the next cycle, not the same cycle.
- A valid result with `hit`=0 and `discard`=0:
  - `found_nonce` takes `inflight[i]` and `hit` is set.
  - If several valid results arrive in the same cycle, the lowest index wins.
  - Later valid results are ignored.
- DISPATCH → DRAIN when any of these occurs:
  - a valid hit;
  - the dispatch of nonce 2^`NONCE_W`−1, which sets `last`;
  - `abort`, which sets `discard`.
- No `core_start` is issued in DRAIN.
- DRAIN exits when all `core_busy` bits are 0:
  - `discard` → IDLE;
  - else `hit` → FOUND;
  - else → EXHAUSTED.
  - If all cores are already idle on entry, the exit happens the next cycle.
- `abort` in DRAIN sets `discard`. `abort` in IDLE/FOUND/EXHAUSTED → IDLE.
- `core_done` on a core that is not busy is ignored and does not count.
- `start` and `abort` in the same cycle: `abort` wins.
- Outputs decode from registered state only. There are no input-to-output combinational paths except `core_start`/`dispatch_nonce`, which depend on registered `core_busy`.

## Timing
- Reset values:
  - state IDLE;
  - all of `core_start`, `dispatch_nonce`, `busy`, `found`, `found_nonce`, `exhausted`, `hash_count` = 0;
  - all `core_busy` clear.
- Reset mid-search drops all in-flight tracking. Cores must be reset by the same `n_rst`.
- `start` → first `core_start` in the next cycle. With all cores idle, dispatches occur on `NUM_CORES` consecutive cycles.
- Valid `core_done` at edge N → DRAIN at N. FOUND/`found` is asserted the cycle after the last busy core completes.

## Configuration
- Macro: `NONCE_SCHED_STATS_EN`.
- Defined:
  - `hash_count` increments on every accepted `core_done`, counting each set bit, up to `NUM_CORES` per cycle.
  - It saturates at 2^32−1 and clears on `start`.
- Undefined: `hash_count` is tied to 0 and the counter logic is absent.

## Test plan
- Round-robin dispatch:
  - Stimulus: `NUM_CORES`=4, `start_nonce`=0x10; no core completes.
  - Required response: `core_start` = 0001, 0010, 0100, 1000 on 4 consecutive cycles with nonces 0x10..0x13, then no further `core_start`.
- Single hit:
  - Stimulus: after the above, core 2 returns done+valid.
  - Required response: DRAIN; the other cores then finish invalid; `found`=1 with `found_nonce`=0x12.
- Simultaneous hits:
  - Stimulus: cores 1 and 3 return done+valid in the same cycle.
  - Required response: `found_nonce`=`inflight[1]`.
- Wrap-around / exhaustion:
  - Stimulus: `start_nonce`=0xFFFFFFFE; both dispatched cores return invalid.
  - Required response: `exhausted`=1; no nonce 0 is ever dispatched.
- Abort:
  - Stimulus: `abort` mid-DISPATCH with 3 cores busy.
  - Required response: no further `core_start`; IDLE after the third `core_done`; `found`=0 even if a result is valid.
- Stats:
  - Stimulus: with `NONCE_SCHED_STATS_EN`, 10 completions, including 2 simultaneous.
  - Required response: `hash_count`=10.
  - Without the macro: `hash_count` stays 0.
